// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - per-bit switch synchroniser and debouncer with rise/fall/change pulses
module switch_debounce #(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_clean,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             changed
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]         s1_q, s2_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         clean_q, clean_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic                     changed_q, changed_d;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // A bit that returns to its clean level at any time restarts qualification.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_q      <= '0;
            s2_q      <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= switch_raw;
            s2_q      <= s1_q;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign switch_clean = clean_q;
    assign switch_rise  = rise_q;
    assign switch_fall  = fall_q;
    assign changed      = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed self-checking bench for switch_debounce
module tb_switch_debounce;

    logic       clk;
    logic       rstb_a, rstb_b;
    logic [7:0] raw_a, raw_b;
    logic [7:0] clean_a, rise_a, fall_a;
    logic [7:0] clean_b, rise_b, fall_b;
    logic       changed_a, changed_b;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    switch_debounce #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(4)) dut_a (
        .clk          (clk),
        .rstb         (rstb_a),
        .switch_raw   (raw_a),
        .switch_clean (clean_a),
        .switch_rise  (rise_a),
        .switch_fall  (fall_a),
        .changed      (changed_a)
    );

    switch_debounce #(.WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(2)) dut_b (
        .clk          (clk),
        .rstb         (rstb_b),
        .switch_raw   (raw_b),
        .switch_clean (clean_b),
        .switch_rise  (rise_b),
        .switch_fall  (fall_b),
        .changed      (changed_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] c, input logic [7:0] r,
                         input logic [7:0] f, input logic ch);
        check({tag, ".clean"},   clean_a, c);
        check({tag, ".rise"},    rise_a, r);
        check({tag, ".fall"},    fall_a, f);
        check({tag, ".changed"}, {7'b0, changed_a}, {7'b0, ch});
    endtask

    task automatic chk_b(input string tag, input logic [7:0] c, input logic [7:0] r,
                         input logic [7:0] f, input logic ch);
        check({tag, ".clean"},   clean_b, c);
        check({tag, ".rise"},    rise_b, r);
        check({tag, ".fall"},    fall_b, f);
        check({tag, ".changed"}, {7'b0, changed_b}, {7'b0, ch});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    logic [7:0] bounce_pat;

    initial begin
        raw_a  = 8'h00;
        raw_b  = 8'h00;
        rstb_a = 1'b1;
        rstb_b = 1'b1;
        #1;
        rstb_a = 1'b0;
        rstb_b = 1'b0;
        raw_a  = 8'hFF;
        #1;
        chk_a("rst_async", 8'h00, 8'h00, 8'h00, 1'b0);
        chk_b("rst_async_b", 8'h00, 8'h00, 8'h00, 1'b0);
        step(2);
        chk_a("rst_held", 8'h00, 8'h00, 8'h00, 1'b0);

        rstb_a = 1'b1;
        rstb_b = 1'b1;
        edges  = 0;
        step(5);
        chk_a("rel_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("rel_e6", 8'hFF, 8'hFF, 8'h00, 1'b1);
        step(1);
        chk_a("rel_e7", 8'hFF, 8'h00, 8'h00, 1'b0);

        raw_a = 8'h00;
        step(6);
        chk_a("all_fall", 8'h00, 8'h00, 8'hFF, 1'b1);
        step(1);

        raw_a = 8'h01;
        step(5);
        chk_a("step_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("step_e6", 8'h01, 8'h01, 8'h00, 1'b1);
        step(1);
        chk_a("step_e7", 8'h01, 8'h00, 8'h00, 1'b0);
        raw_a = 8'h00;
        step(5);
        chk_a("stepf_e5", 8'h01, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("stepf_e6", 8'h00, 8'h00, 8'h01, 1'b1);
        step(1);

        bounce_pat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            raw_a = bounce_pat[k] ? 8'h08 : 8'h00;
            step(1);
            check("bounce.clean", clean_a, 8'h00);
            check("bounce.changed", {7'b0, changed_a}, 8'h00);
        end
        raw_a = 8'h08;
        step(5);
        chk_a("hold_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("hold_e6", 8'h08, 8'h08, 8'h00, 1'b1);
        step(1);

        raw_a = 8'h0F;
        step(6);
        chk_a("to0f", 8'h0F, 8'h07, 8'h00, 1'b1);
        step(1);
        raw_a = 8'hF0;
        step(5);
        chk_a("simul_e5", 8'h0F, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("simul_e6", 8'hF0, 8'hF0, 8'h0F, 1'b1);
        step(1);
        chk_a("simul_e7", 8'hF0, 8'h00, 8'h00, 1'b0);

        while (edges % 4 != 0) step(1);
        raw_b = 8'h01;
        step(7);
        chk_b("presc_r7", 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_b("presc_r8", 8'h01, 8'h01, 8'h00, 1'b1);
        step(1);
        chk_b("presc_r9", 8'h01, 8'h00, 8'h00, 1'b0);
        raw_b = 8'h00;
        step(6);
        chk_b("presc_f15", 8'h01, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_b("presc_f16", 8'h00, 8'h00, 8'h01, 1'b1);
        step(1);
        chk_b("presc_f17", 8'h00, 8'h00, 8'h00, 1'b0);

        raw_a = 8'hF1;
        step(4);
        chk_a("mid_e4", 8'hF0, 8'h00, 8'h00, 1'b0);
        #2;
        rstb_a = 1'b0;
        #1;
        chk_a("mid_async", 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("mid_held", 8'h00, 8'h00, 8'h00, 1'b0);
        rstb_a = 1'b1;
        step(5);
        chk_a("requal_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        chk_a("requal_e6", 8'hF1, 8'hF1, 8'h00, 1'b1);
        step(1);
        chk_a("requal_e7", 8'hF1, 8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
